// File: rtl/vga_pkg.sv
// XGA timing constants, counter width and small decode helpers shared by the
// timing generator and every draw stage on the pixel-stream timing bus.
package vga_pkg;

    localparam int unsigned CNT_W = 11;

    localparam int unsigned XGA_H_ACTIVE     = 1024;
    localparam int unsigned XGA_H_SYNC_START = 1048;
    localparam int unsigned XGA_H_SYNC_W     = 136;
    localparam int unsigned XGA_H_TOTAL      = 1344;
    localparam int unsigned XGA_V_ACTIVE     = 768;
    localparam int unsigned XGA_V_SYNC_START = 771;
    localparam int unsigned XGA_V_SYNC_W     = 6;
    localparam int unsigned XGA_V_TOTAL      = 806;
    localparam logic        XGA_SYNC_POL     = 1'b0;

    typedef logic [CNT_W-1:0] count_t;

    // RESTART holds the counters at (0,0) for one edge after reset so the
    // frame_start strobe lines up with the first visible (0,0) cycle.
    typedef enum logic {
        ST_RESTART = 1'b0,
        ST_RUN     = 1'b1
    } gen_state_t;

    function automatic logic in_window(input count_t value,
                                       input int unsigned lo,
                                       input int unsigned width);
        return (32'(value) >= lo) && (32'(value) < lo + width);
    endfunction

    function automatic logic in_active_area(input count_t hcount,
                                            input count_t vcount);
        return (32'(hcount) < XGA_H_ACTIVE) && (32'(vcount) < XGA_V_ACTIVE);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus sync/blank decode of the next count,
// so the parent can register flags in step with the count register.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE     = XGA_H_ACTIVE,
    parameter int unsigned SYNC_START = XGA_H_SYNC_START,
    parameter int unsigned SYNC_W     = XGA_H_SYNC_W,
    parameter int unsigned TOTAL      = XGA_H_TOTAL
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync_next,
    output logic             blank_next
);

    localparam count_t LAST = count_t'(TOTAL - 1);

    count_t count_next;

    // Out-of-range values (only reachable by forcing) fall back to 0 at once.
    always_comb begin
        count_next = count;
        wrap       = 1'b0;
        if (count > LAST) begin
            count_next = '0;
            wrap       = 1'b1;
        end else if (inc_en) begin
            if (count == LAST) begin
                count_next = '0;
                wrap       = 1'b1;
            end else begin
                count_next = count + count_t'(1);
            end
        end
    end

    always_comb begin
        sync_next  = in_window(count_next, SYNC_START, SYNC_W);
        blank_next = (32'(count_next) >= ACTIVE);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Head of the display chain: hcount/vcount, syncs, blanks and frame_start,
// all registered with zero skew between counts and flags.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = XGA_H_ACTIVE,
    parameter int unsigned H_SYNC_START = XGA_H_SYNC_START,
    parameter int unsigned H_SYNC_W     = XGA_H_SYNC_W,
    parameter int unsigned H_TOTAL      = XGA_H_TOTAL,
    parameter int unsigned V_ACTIVE     = XGA_V_ACTIVE,
    parameter int unsigned V_SYNC_START = XGA_V_SYNC_START,
    parameter int unsigned V_SYNC_W     = XGA_V_SYNC_W,
    parameter int unsigned V_TOTAL      = XGA_V_TOTAL,
    parameter logic        SYNC_POL     = XGA_SYNC_POL
) (
    input  logic             pclk,
    input  logic             rst,
    output logic [CNT_W-1:0] hcount_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic             frame_start
);

    gen_state_t state;
    gen_state_t state_next;
    logic       h_inc;
    logic       h_wrap;
    logic       v_wrap;
    logic       h_sync_next;
    logic       v_sync_next;
    logic       h_blank_next;
    logic       v_blank_next;
    logic       frame_next;

    vga_axis_counter #(
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_SYNC_START),
        .SYNC_W     (H_SYNC_W),
        .TOTAL      (H_TOTAL)
    ) u_haxis (
        .pclk       (pclk),
        .rst        (rst),
        .inc_en     (h_inc),
        .count      (hcount_out),
        .wrap       (h_wrap),
        .sync_next  (h_sync_next),
        .blank_next (h_blank_next)
    );

    // The vertical axis only steps on the horizontal wrap, so vsync can only
    // change on the hcount==0 cycle of a line.
    vga_axis_counter #(
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_SYNC_START),
        .SYNC_W     (V_SYNC_W),
        .TOTAL      (V_TOTAL)
    ) u_vaxis (
        .pclk       (pclk),
        .rst        (rst),
        .inc_en     (h_wrap),
        .count      (vcount_out),
        .wrap       (v_wrap),
        .sync_next  (v_sync_next),
        .blank_next (v_blank_next)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= ST_RESTART;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        h_inc      = 1'b0;
        frame_next = 1'b0;
        case (state)
            ST_RESTART: begin
                state_next = ST_RUN;
                frame_next = 1'b1;
            end
            ST_RUN: begin
                h_inc      = 1'b1;
                frame_next = h_wrap && v_wrap;
            end
            default: begin
                state_next = ST_RESTART;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hsync_out   <= ~SYNC_POL;
            vsync_out   <= ~SYNC_POL;
            hblnk_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync_out   <= h_sync_next ? SYNC_POL : ~SYNC_POL;
            vsync_out   <= v_sync_next ? SYNC_POL : ~SYNC_POL;
            hblnk_out   <= h_blank_next;
            vblnk_out   <= v_blank_next;
            frame_start <= frame_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: XGA instance plus two shrunken-timing instances
// (both sync polarities) checked every cycle against a reference model.
module tb_vga_timing_gen;

    localparam int S_HA  = 16;
    localparam int S_HSS = 18;
    localparam int S_HSW = 4;
    localparam int S_HT  = 24;
    localparam int S_VA  = 10;
    localparam int S_VSS = 11;
    localparam int S_VSW = 2;
    localparam int S_VT  = 14;
    localparam int S_FRAME = S_HT * S_VT;

    typedef struct packed {
        int ha; int hss; int hsw; int ht;
        int va; int vss; int vsw; int vt;
    } timing_t;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        fs;
    } obs_t;

    typedef struct packed {
        int   h;
        int   v;
        logic pending;
        logic fs;
    } model_t;

    typedef struct {
        int   which;
        obs_t exp;
    } sb_t;

    typedef struct {
        logic rst;
        int   cycles;
        obs_t exp;
    } vec_t;

    localparam timing_t T_XGA   = '{1024, 1048, 136, 1344, 768, 771, 6, 806};
    localparam timing_t T_SMALL = '{S_HA, S_HSS, S_HSW, S_HT, S_VA, S_VSS, S_VSW, S_VT};

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    always #5 pclk = ~pclk;

    logic [10:0] x_h, x_v, s_h, s_v, p_h, p_v;
    logic x_hs, x_vs, x_hb, x_vb, x_fs;
    logic s_hs, s_vs, s_hb, s_vb, s_fs;
    logic p_hs, p_vs, p_hb, p_vb, p_fs;

    vga_timing_gen dut_xga (
        .pclk(pclk), .rst(rst), .hcount_out(x_h), .vcount_out(x_v),
        .hsync_out(x_hs), .vsync_out(x_vs), .hblnk_out(x_hb), .vblnk_out(x_vb),
        .frame_start(x_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_SYNC_START(S_HSS), .H_SYNC_W(S_HSW), .H_TOTAL(S_HT),
        .V_ACTIVE(S_VA), .V_SYNC_START(S_VSS), .V_SYNC_W(S_VSW), .V_TOTAL(S_VT),
        .SYNC_POL(1'b0)
    ) dut_small (
        .pclk(pclk), .rst(rst), .hcount_out(s_h), .vcount_out(s_v),
        .hsync_out(s_hs), .vsync_out(s_vs), .hblnk_out(s_hb), .vblnk_out(s_vb),
        .frame_start(s_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_SYNC_START(S_HSS), .H_SYNC_W(S_HSW), .H_TOTAL(S_HT),
        .V_ACTIVE(S_VA), .V_SYNC_START(S_VSS), .V_SYNC_W(S_VSW), .V_TOTAL(S_VT),
        .SYNC_POL(1'b1)
    ) dut_pos (
        .pclk(pclk), .rst(rst), .hcount_out(p_h), .vcount_out(p_v),
        .hsync_out(p_hs), .vsync_out(p_vs), .hblnk_out(p_hb), .vblnk_out(p_vb),
        .frame_start(p_fs)
    );

    int     tests    = 0;
    int     failures = 0;
    sb_t    sb_q[$];
    model_t m_xga    = '{0, 0, 1'b1, 1'b0};
    model_t m_small  = '{0, 0, 1'b1, 1'b0};
    vec_t   vecs[11];

    function automatic model_t step(model_t m, logic r, timing_t t);
        model_t n = m;
        if (r) begin
            n.h = 0; n.v = 0; n.pending = 1'b1; n.fs = 1'b0;
        end else if (m.pending) begin
            n.h = 0; n.v = 0; n.pending = 1'b0; n.fs = 1'b1;
        end else begin
            n.h = m.h + 1;
            if (n.h == t.ht) begin
                n.h = 0;
                n.v = m.v + 1;
                if (n.v == t.vt) n.v = 0;
            end
            n.fs = (n.h == 0) && (n.v == 0);
        end
        return n;
    endfunction

    function automatic obs_t expect_of(model_t m, timing_t t, logic pol);
        obs_t o;
        o.h  = 11'(m.h);
        o.v  = 11'(m.v);
        o.hs = (m.h >= t.hss && m.h < t.hss + t.hsw) ? pol : ~pol;
        o.vs = (m.v >= t.vss && m.v < t.vss + t.vsw) ? pol : ~pol;
        o.hb = (m.h >= t.ha);
        o.vb = (m.v >= t.va);
        o.fs = m.fs;
        return o;
    endfunction

    function automatic obs_t mk(int h, int v, logic hs, logic vs, logic hb, logic vb, logic fs);
        obs_t o;
        o.h = 11'(h); o.v = 11'(v);
        o.hs = hs; o.vs = vs; o.hb = hb; o.vb = vb; o.fs = fs;
        return o;
    endfunction

    function automatic vec_t mkvec(logic r, int cycles, obs_t exp);
        vec_t v;
        v.rst = r; v.cycles = cycles; v.exp = exp;
        return v;
    endfunction

    function automatic obs_t observe(int which);
        case (which)
            0:       return {x_h, x_v, x_hs, x_vs, x_hb, x_vb, x_fs};
            1:       return {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs};
            default: return {p_h, p_v, p_hs, p_vs, p_hb, p_vb, p_fs};
        endcase
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
                         o.h, o.v, o.hs, o.vs, o.hb, o.vb, o.fs);
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r);
        rst = r;
        @(posedge pclk);
        m_xga   = step(m_xga, r, T_XGA);
        m_small = step(m_small, r, T_SMALL);
        sb_q.push_back('{0, expect_of(m_xga, T_XGA, 1'b0)});
        sb_q.push_back('{1, expect_of(m_small, T_SMALL, 1'b0)});
        sb_q.push_back('{2, expect_of(m_small, T_SMALL, 1'b1)});
    endtask

    task automatic checkOutput();
        sb_t e;
        @(negedge pclk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_obs($sformatf("sb_dut%0d", e.which), observe(e.which), e.exp);
        end
    endtask

    task automatic tick(input logic r);
        applyStimulus(r);
        checkOutput();
    endtask

    int   period;
    int   lines, bad_lines, line_low, line_pulse;
    int   hs_low, hs_pulses, frames, vs_bad, vs_low, vb_cyc, hb_cyc;
    int   pos_hs_high, pos_vs_high;
    logic prev_hs, prev_vs;

    initial begin
        vecs[0]  = mkvec(1'b1, 3,    mk(0,    0, 1, 1, 0, 0, 0));
        vecs[1]  = mkvec(1'b0, 1,    mk(0,    0, 1, 1, 0, 0, 1));
        vecs[2]  = mkvec(1'b0, 1023, mk(1023, 0, 1, 1, 0, 0, 0));
        vecs[3]  = mkvec(1'b0, 1,    mk(1024, 0, 1, 1, 1, 0, 0));
        vecs[4]  = mkvec(1'b0, 23,   mk(1047, 0, 1, 1, 1, 0, 0));
        vecs[5]  = mkvec(1'b0, 1,    mk(1048, 0, 0, 1, 1, 0, 0));
        vecs[6]  = mkvec(1'b0, 135,  mk(1183, 0, 0, 1, 1, 0, 0));
        vecs[7]  = mkvec(1'b0, 1,    mk(1184, 0, 1, 1, 1, 0, 0));
        vecs[8]  = mkvec(1'b0, 159,  mk(1343, 0, 1, 1, 1, 0, 0));
        vecs[9]  = mkvec(1'b0, 1,    mk(0,    1, 1, 1, 0, 0, 0));
        vecs[10] = mkvec(1'b0, 2688, mk(0,    3, 1, 1, 0, 0, 0));

        for (int i = 0; i < 11; i++) begin
            repeat (vecs[i].cycles) tick(vecs[i].rst);
            check_obs($sformatf("xga_vec%0d", i), observe(0), vecs[i].exp);
        end

        // Align the shrunken instances to a frame start, then watch two frames.
        for (int i = 0; i < S_FRAME + 4 && s_fs !== 1'b1; i++) tick(1'b0);
        check_int("sync_to_frame", int'(s_fs), 1);

        lines = 0; bad_lines = 0; line_low = 0; line_pulse = 0;
        hs_low = 0; hs_pulses = 0; frames = 0; vs_bad = 0; vs_low = 0;
        vb_cyc = 0; hb_cyc = 0; pos_hs_high = 0; pos_vs_high = 0;
        prev_hs = s_hs; prev_vs = s_vs;
        for (int n = 0; n < 2 * S_FRAME; n++) begin
            if (!s_hs) begin hs_low++; line_low++; end
            if (prev_hs && !s_hs) begin hs_pulses++; line_pulse++; end
            if (s_vs != prev_vs && s_h != 11'd0) vs_bad++;
            if (!s_vs) vs_low++;
            if (s_vb) vb_cyc++;
            if (s_hb) hb_cyc++;
            if (p_hs) pos_hs_high++;
            if (p_vs) pos_vs_high++;
            if (s_fs) frames++;
            if (int'(s_h) == S_HT - 1) begin
                if (line_low != S_HSW || line_pulse != 1) bad_lines++;
                line_low = 0; line_pulse = 0; lines++;
            end
            prev_hs = s_hs; prev_vs = s_vs;
            tick(1'b0);
        end
        check_int("lines_seen", lines, 2 * S_VT);
        check_int("bad_lines", bad_lines, 0);
        check_int("hsync_pulses", hs_pulses, 2 * S_VT);
        check_int("hsync_low_cycles", hs_low, 2 * S_VT * S_HSW);
        check_int("frame_starts", frames, 2);
        check_int("vsync_midline_edges", vs_bad, 0);
        check_int("vsync_low_cycles", vs_low, 2 * S_VSW * S_HT);
        check_int("vblank_cycles", vb_cyc, 2 * (S_VT - S_VA) * S_HT);
        check_int("hblank_cycles", hb_cyc, 2 * S_VT * (S_HT - S_HA));
        check_int("pos_hsync_high", pos_hs_high, 2 * S_VT * S_HSW);
        check_int("pos_vsync_high", pos_vs_high, 2 * S_VSW * S_HT);

        period = 0;
        do begin
            tick(1'b0);
            period++;
        end while (s_fs !== 1'b1 && period < S_FRAME + 4);
        check_int("frame_period", period, S_FRAME);

        for (int i = 0; i < S_FRAME + 4 && !(int'(s_h) == S_HT - 1 && int'(s_v) == S_VT - 1); i++)
            tick(1'b0);
        check_obs("wrap_pre", observe(1), mk(S_HT - 1, S_VT - 1, 1, 1, 1, 1, 0));
        tick(1'b0);
        check_obs("wrap_post", observe(1), mk(0, 0, 1, 1, 0, 0, 1));

        for (int i = 0; i < S_FRAME + 4 && !(s_h == 11'd12 && s_v == 11'd6); i++)
            tick(1'b0);
        check_obs("midrst_pre", observe(1), mk(12, 6, 1, 1, 0, 0, 0));
        tick(1'b1);
        check_obs("midrst_reset", observe(1), mk(0, 0, 1, 1, 0, 0, 0));
        check_obs("midrst_reset_pos", observe(2), mk(0, 0, 0, 0, 0, 0, 0));
        tick(1'b0);
        check_obs("midrst_restart", observe(1), mk(0, 0, 1, 1, 0, 0, 1));
        tick(1'b0);
        check_obs("midrst_count", observe(1), mk(1, 0, 1, 1, 0, 0, 0));
        repeat (S_HT) tick(1'b0);
        check_obs("midrst_line1", observe(1), mk(1, 1, 1, 1, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
